// File: rtl/input_state.sv
// Player-input stage of the Simon Says core.
// Synchronises and debounces the four colour buttons, checks each press
// against the packed colour sequence, echoes the held colour onto the LED
// bus and reports a one-cycle pass or fail pulse to the game controller.
module input_state #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_input,
    input  logic        en_input,
    input  logic [31:0] seq_in_input,
    input  logic [3:0]  round_ctr,
    input  logic [3:0]  btn,
    output logic [1:0]  colour_echo,
    output logic        echo_oe,
    output logic        complete_input,
    output logic        fail_input
);

    // state        | meaning
    // S_IDLE       | waiting for en_input, progress cleared
    // S_WAIT_PRESS | armed, waiting for the next debounced press (timed)
    // S_WAIT_REL   | correct colour held and echoed, waiting for release
    // S_HOLD       | round finished (pass or fail), waiting for en_input low
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_PRESS = 2'd1;
    localparam logic [1:0] S_WAIT_REL   = 2'd2;
    localparam logic [1:0] S_HOLD       = 2'd3;

    // A one-cycle debounce or timeout would give a zero-width counter.
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 1)  ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]     sync1;
    logic [3:0]     sync2;
    logic [3:0]     btn_last;
    logic [DBW-1:0] db_cnt;
    logic [3:0]     btn_db;
    logic [3:0]     btn_db_q;

    logic [1:0]     state;
    logic [3:0]     pos;
    logic [3:0]     last_pos;
    logic [TW-1:0]  tmo_cnt;

    logic           press_ev;
    logic           is_onehot;
    logic [1:0]     btn_enc;
    logic [1:0]     exp_colour;

    // Two-flop synchroniser for the raw asynchronous buttons.
    always_ff @(posedge clk or posedge rst_input) begin
        if (rst_input) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Debouncer: accept a vector only after it has been stable long enough.
    always_ff @(posedge clk or posedge rst_input) begin
        if (rst_input) begin
            btn_last <= 4'b0000;
            db_cnt   <= '0;
            btn_db   <= 4'b0000;
        end else if (sync2 != btn_last) begin
            btn_last <= sync2;
            db_cnt   <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db   <= btn_last;
        end else begin
            db_cnt   <= db_cnt + DBW'(1);
        end
    end

    // Registered copy of the debounced vector for press-edge detection.
    always_ff @(posedge clk or posedge rst_input) begin
        if (rst_input) begin
            btn_db_q <= 4'b0000;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    assign press_ev   = (btn_db_q == 4'b0000) && (btn_db != 4'b0000);
    assign exp_colour = seq_in_input[{pos, 1'b0} +: 2];

    // Classify the debounced vector: exactly one button, and which colour.
    always_comb begin
        is_onehot = 1'b0;
        btn_enc   = 2'd0;
        case (btn_db)
            4'b0001: begin is_onehot = 1'b1; btn_enc = 2'd0; end
            4'b0010: begin is_onehot = 1'b1; btn_enc = 2'd1; end
            4'b0100: begin is_onehot = 1'b1; btn_enc = 2'd2; end
            4'b1000: begin is_onehot = 1'b1; btn_enc = 2'd3; end
            default: begin is_onehot = 1'b0; btn_enc = 2'd0; end
        endcase
    end

    // Round sequencing FSM with registered echo and result pulses.
    always_ff @(posedge clk or posedge rst_input) begin
        if (rst_input) begin
            state          <= S_IDLE;
            pos            <= 4'd0;
            last_pos       <= 4'd0;
            tmo_cnt        <= '0;
            colour_echo    <= 2'b00;
            echo_oe        <= 1'b0;
            complete_input <= 1'b0;
            fail_input     <= 1'b0;
        end else begin
            complete_input <= 1'b0;
            fail_input     <= 1'b0;
            case (state)
                S_IDLE: begin
                    pos     <= 4'd0;
                    tmo_cnt <= '0;
                    echo_oe <= 1'b0;
                    if (en_input) begin
                        last_pos <= round_ctr;
                        state    <= S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    if (!en_input) begin
                        echo_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else if (press_ev) begin
                        if (is_onehot && (btn_enc == exp_colour)) begin
                            colour_echo <= btn_enc;
                            echo_oe     <= 1'b1;
                            state       <= S_WAIT_REL;
                        end else begin
                            fail_input  <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (tmo_cnt == TO_LAST) begin
                        fail_input <= 1'b1;
                        state      <= S_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WAIT_REL: begin
                    if (!en_input) begin
                        echo_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else if (btn_db == 4'b0000) begin
                        echo_oe <= 1'b0;
                        tmo_cnt <= '0;
                        // Completion is decided before pos moves, so 16 presses never wrap.
                        if (pos == last_pos) begin
                            complete_input <= 1'b1;
                            state          <= S_HOLD;
                        end else begin
                            pos   <= pos + 4'd1;
                            state <= S_WAIT_PRESS;
                        end
                    end
                end
                default: begin
                    echo_oe <= 1'b0;
                    if (!en_input) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_state.sv
// Randomised self-checking bench for input_state with short debounce/timeout.
module tb_input_state;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] seq;
    logic [3:0]  round_ctr;
    logic [3:0]  btn;
    logic [1:0]  colour_echo;
    logic        echo_oe;
    logic        complete_input;
    logic        fail_input;

    int checks   = 0;
    int errors   = 0;
    int n_complete = 0;
    int n_fail   = 0;
    int n_both   = 0;
    int n_wide   = 0;
    logic prev_c = 1'b0;
    logic prev_f = 1'b0;

    logic [3:0] plan [16];

    input_state #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk            (clk),
        .rst_input      (rst),
        .en_input       (en),
        .seq_in_input   (seq),
        .round_ctr      (round_ctr),
        .btn            (btn),
        .colour_echo    (colour_echo),
        .echo_oe        (echo_oe),
        .complete_input (complete_input),
        .fail_input     (fail_input)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (complete_input) n_complete++;
        if (fail_input) n_fail++;
        if (complete_input && fail_input) n_both++;
        if ((complete_input && prev_c) || (fail_input && prev_f)) n_wide++;
        prev_c = complete_input;
        prev_f = fail_input;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Arm, play plan[0..n_do-1] as clean presses, judge each against the sequence.
    task automatic run_round(input logic [31:0] s, input logic [3:0] rc, input int n_do);
        int c0;
        int f0;
        bit failed;
        logic [1:0] col;
        logic [3:0] want;
        c0 = n_complete;
        f0 = n_fail;
        failed = 1'b0;
        seq = s;
        round_ctr = rc;
        en = 1'b1;
        tick(2);
        round_ctr = 4'($urandom);
        for (int i = 0; i < n_do && !failed; i++) begin
            col  = s[2*i +: 2];
            want = 4'b0001 << col;
            btn = plan[i];
            tick(12);
            if (plan[i] == want) begin
                chk("echo_oe_held", 32'(echo_oe), 32'd1);
                chk("colour_echo", 32'(colour_echo), 32'(col));
                chk("no_fail_yet", 32'(n_fail - f0), 32'd0);
            end else begin
                chk("echo_oe_on_fail", 32'(echo_oe), 32'd0);
                chk("fail_pulse", 32'(n_fail - f0), 32'd1);
                failed = 1'b1;
            end
            btn = 4'b0000;
            tick(12);
            if (!failed) begin
                chk("echo_oe_released", 32'(echo_oe), 32'd0);
                chk("complete_when", 32'(n_complete - c0), (i == int'(rc)) ? 32'd1 : 32'd0);
            end
        end
        chk("round_complete_cnt", 32'(n_complete - c0),
            (!failed && n_do == int'(rc) + 1) ? 32'd1 : 32'd0);
        chk("round_fail_cnt", 32'(n_fail - f0), failed ? 32'd1 : 32'd0);
    endtask

    task automatic end_round();
        en = 1'b0;
        tick(3);
    endtask

    initial begin
        int c0;
        int f0;
        int n;
        int k;
        int rc;
        logic [31:0] s;
        logic [1:0] col;

        rst = 1'b1;
        en = 1'b0;
        seq = 32'h0;
        round_ctr = 4'd0;
        btn = 4'b0000;

        // Reset with buttons toggling.
        for (int i = 0; i < 10; i++) begin
            btn = 4'($urandom);
            tick(1);
        end
        chk("rst_colour_echo", 32'(colour_echo), 32'd0);
        chk("rst_echo_oe", 32'(echo_oe), 32'd0);
        chk("rst_complete", 32'(complete_input), 32'd0);
        chk("rst_fail", 32'(fail_input), 32'd0);
        btn = 4'b0000;
        rst = 1'b0;
        tick(12);
        chk("post_rst_no_pulse", 32'(n_complete + n_fail), 32'd0);

        // Ordered colours 0,1,2,3.
        for (int i = 0; i < 4; i++) plan[i] = 4'b0001 << i;
        run_round(32'h0000_00E4, 4'd3, 4);
        end_round();

        // Wrong second colour, then stuck in HOLD until en drops.
        plan[0] = 4'b0001;
        plan[1] = 4'b1000;
        run_round(32'h0000_00E4, 4'd3, 2);
        c0 = n_complete;
        f0 = n_fail;
        btn = 4'b0010;
        tick(12);
        chk("hold_ignores_press", 32'(echo_oe), 32'd0);
        btn = 4'b0000;
        tick(12);
        chk("hold_no_pulse", 32'(n_complete - c0 + n_fail - f0), 32'd0);
        end_round();

        // Two buttons at once.
        plan[0] = 4'b0101;
        run_round(32'h0000_00E4, 4'd3, 1);
        end_round();

        // Chatter on btn[1], then a clean hold.
        c0 = n_complete;
        f0 = n_fail;
        seq = 32'h5555_5555;
        round_ctr = 4'd0;
        en = 1'b1;
        tick(2);
        n = 0;
        while (n < 30) begin
            k = $urandom_range(1, 3);
            btn = btn ^ 4'b0010;
            tick(k);
            n += k;
        end
        btn = 4'b0010;
        tick(12);
        chk("chatter_echo_oe", 32'(echo_oe), 32'd1);
        chk("chatter_colour", 32'(colour_echo), 32'd1);
        btn = 4'b0000;
        tick(12);
        chk("chatter_complete", 32'(n_complete - c0), 32'd1);
        chk("chatter_no_fail", 32'(n_fail - f0), 32'd0);
        end_round();

        // Timeout with no press.
        f0 = n_fail;
        seq = 32'h0;
        round_ctr = 4'd0;
        en = 1'b1;
        n = 0;
        while (n_fail == f0 && n < 200) begin
            tick(1);
            n++;
        end
        chk("timeout_latency_ok", 32'((n >= 100) && (n <= 102)), 32'd1);
        end_round();

        // Sixteen presses, first aborted after five, then played through.
        for (int i = 0; i < 16; i++) plan[i] = 4'b0001;
        c0 = n_complete;
        f0 = n_fail;
        run_round(32'h0, 4'd15, 5);
        end_round();
        chk("abort_echo_oe", 32'(echo_oe), 32'd0);
        chk("abort_no_pulse", 32'(n_complete - c0 + n_fail - f0), 32'd0);
        run_round(32'h0, 4'd15, 16);
        end_round();

        // Random rounds, some with an injected wrong or multi-button press.
        for (int r = 0; r < 20; r++) begin
            rc = $urandom_range(0, 5);
            s = $urandom;
            for (int i = 0; i < 16; i++) begin
                col = s[2*i +: 2];
                plan[i] = 4'b0001 << col;
            end
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, rc);
                col = s[2*k +: 2];
                if ($urandom_range(0, 1) == 1)
                    plan[k] = 4'b0001 << 2'(col + 2'(1 + $urandom_range(0, 2)));
                else
                    plan[k] = plan[k] | (4'b0001 << 2'(col + 2'(1 + $urandom_range(0, 2))));
            end
            run_round(s, 4'(rc), rc + 1);
            end_round();
        end

        // Reset mid WAIT_RELEASE clears echo asynchronously, no pulse follows.
        c0 = n_complete;
        f0 = n_fail;
        seq = 32'h0000_0002;
        round_ctr = 4'd0;
        en = 1'b1;
        tick(2);
        btn = 4'b0100;
        tick(12);
        chk("pre_rst_echo_oe", 32'(echo_oe), 32'd1);
        #1;
        rst = 1'b1;
        en = 1'b0;
        #1;
        chk("async_rst_echo_oe", 32'(echo_oe), 32'd0);
        btn = 4'b0000;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("rst_no_pulse", 32'(n_complete - c0 + n_fail - f0), 32'd0);

        chk("never_simultaneous", 32'(n_both), 32'd0);
        chk("single_cycle_pulses", 32'(n_wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
